// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 sensor emulator: timing FSM states,
// the RGB565 pixel type and the colour-bar palette.
package ov7670_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } state_t;

  typedef logic [15:0] rgb565_t;

  // White, yellow, cyan, green, magenta, red, blue, black
  localparam rgb565_t BAR_COLORS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

endpackage

// File: rtl/ov7670_sensor_emulator_if.sv
// Pixel-port bundle between the emulated sensor (master) and the capture logic (slave).
interface ov7670_sensor_emulator_if;

  logic       enable;
  logic       patternSel;
  logic       pclk;
  logic       vsync;
  logic       href;
  logic [7:0] data;
  logic       frameStart;

  modport master (
    input  enable, patternSel,
    output pclk, vsync, href, data, frameStart
  );

  modport slave (
    output enable, patternSel,
    input  pclk, vsync, href, data, frameStart
  );

endinterface

// File: rtl/ov7670_pattern_gen.sv
// Test-pattern source: colour bars from a bar-width counter and bar index, or a
// 16-bit pixel counter running continuously across the frame.
module ov7670_pattern_gen
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = 320,
  parameter int COL_W    = $clog2(H_ACTIVE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             frame_start,
  input  logic             active,
  input  logic             phase,
  input  logic             pattern_sel,
  input  logic [COL_W-1:0] col,
  output logic [7:0]       data
);

  localparam int               BAR_W    = H_ACTIVE / 8;
  localparam int               WW       = $clog2(BAR_W + 1);
  localparam logic [WW-1:0]    W_LAST   = WW'(BAR_W - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);

  logic [WW-1:0] bar_w;
  logic [2:0]    bar_idx;
  rgb565_t       pix_cnt;
  rgb565_t       pixel;
  logic          low_done;

  assign low_done = tick && active && phase;

  // Both counters advance only once the low byte of a pixel has gone out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bar_w   <= '0;
      bar_idx <= '0;
      pix_cnt <= '0;
    end else if (frame_start) begin
      bar_w   <= '0;
      bar_idx <= '0;
      pix_cnt <= '0;
    end else if (low_done) begin
      pix_cnt <= pix_cnt + 16'd1;
      if (col == COL_LAST) begin
        bar_w   <= '0;
        bar_idx <= '0;
      end else if (bar_w == W_LAST) begin
        bar_w   <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_w <= bar_w + WW'(1);
      end
    end
  end

  always_comb begin
    pixel = pattern_sel ? pix_cnt : BAR_COLORS[bar_idx];
    data  = 8'h00;
    if (active) data = phase ? pixel[7:0] : pixel[15:8];
  end

endmodule

// File: rtl/ov7670_sensor_emulator.sv
// OV7670 pixel-port emulator: pclk at clk/2, frame timing FSM and line/byte counters,
// with all outputs changing only on the clk edge that drives pclk low.
module ov7670_sensor_emulator
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = 320,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_ACTIVE = 240,
  parameter int V_FRONT  = 10
) (
  input logic                      clk,
  input logic                      reset,
  ov7670_sensor_emulator_if.master cam
);

  localparam int LINE = 2 * H_ACTIVE + H_BLANK;
  localparam int BW   = $clog2(LINE);
  localparam int LW   = $clog2(V_SYNC + V_BACK + V_ACTIVE + V_FRONT + 1);
  localparam int CW   = $clog2(H_ACTIVE);

  localparam logic [BW-1:0] BYTE_LAST  = BW'(LINE - 1);
  localparam logic [BW-1:0] ACT_BYTES  = BW'(2 * H_ACTIVE);
  localparam logic [LW-1:0] SYNC_LAST  = LW'(V_SYNC - 1);
  localparam logic [LW-1:0] BACK_LAST  = LW'(V_BACK - 1);
  localparam logic [LW-1:0] ACT_LAST   = LW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] FRONT_LAST = LW'(V_FRONT - 1);

  state_t        state, state_next;
  logic [BW-1:0] byte_cnt;
  logic [LW-1:0] line_cnt;
  logic          pclk_q, tick, line_end, frame_begin;
  logic          pattern_q, fs_q;
  logic          vsync_c, href_c;
  logic [7:0]    pattern_data;

  // A tick is the clk edge where pclk falls; every piece of state moves only then.
  assign tick        = pclk_q;
  assign line_end    = (byte_cnt == BYTE_LAST);
  assign frame_begin = tick && (state_next == VSYNC) && (state != VSYNC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      byte_cnt <= '0;
      line_cnt <= '0;
    end else if (tick) begin
      state <= state_next;
      if (state == IDLE || line_end) byte_cnt <= '0;
      else                           byte_cnt <= byte_cnt + BW'(1);
      if (state_next != state) line_cnt <= '0;
      else if (line_end)       line_cnt <= line_cnt + LW'(1);
    end
  end

  // Empty back/front porches are skipped rather than held for a line.
  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        IDLE:    if (cam.enable) state_next = VSYNC;
        VSYNC:   if (line_end && line_cnt == SYNC_LAST)
                   state_next = (V_BACK > 0) ? VBACK : ACTIVE;
        VBACK:   if (line_end && line_cnt == BACK_LAST) state_next = ACTIVE;
        ACTIVE:  if (line_end && line_cnt == ACT_LAST)
                   state_next = (V_FRONT > 0) ? VFRONT : (cam.enable ? VSYNC : IDLE);
        VFRONT:  if (line_end && line_cnt == FRONT_LAST)
                   state_next = cam.enable ? VSYNC : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    vsync_c = (state == VSYNC);
    href_c  = (state == ACTIVE) && (byte_cnt < ACT_BYTES);
  end

  // The pattern choice is frozen for the whole frame at the vsync rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pclk_q    <= 1'b0;
      fs_q      <= 1'b0;
      pattern_q <= 1'b0;
    end else begin
      pclk_q <= ~pclk_q;
      fs_q   <= frame_begin;
      if (frame_begin) pattern_q <= cam.patternSel;
    end
  end

  ov7670_pattern_gen #(.H_ACTIVE(H_ACTIVE)) u_pattern (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .frame_start(frame_begin),
    .active     (href_c),
    .phase      (byte_cnt[0]),
    .pattern_sel(pattern_q),
    .col        (byte_cnt[CW:1]),
    .data       (pattern_data)
  );

  assign cam.pclk       = pclk_q;
  assign cam.vsync      = vsync_c;
  assign cam.href       = href_c;
  assign cam.data       = pattern_data;
  assign cam.frameStart = fs_q;

endmodule

// File: tb/tb_ov7670_sensor_emulator.sv
// Directed bench for the OV7670 emulator: frame timing checks plus a pixel scoreboard
// filled with the expected frame content whenever a frame is requested.
module tb_ov7670_sensor_emulator;

  localparam int H_ACTIVE = 16;
  localparam int H_BLANK  = 4;
  localparam int V_SYNC   = 1;
  localparam int V_BACK   = 1;
  localparam int V_ACTIVE = 2;
  localparam int V_FRONT  = 1;
  localparam int LINE     = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME_TP = (V_SYNC + V_BACK + V_ACTIVE + V_FRONT) * LINE;

  localparam logic [15:0] BAR_TAB [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  logic clk = 1'b0;
  logic reset;

  ov7670_sensor_emulator_if cam();

  ov7670_sensor_emulator #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_SYNC(V_SYNC),
    .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .cam  (cam)
  );

  always #5 clk = ~clk;

  int          compared = 0;
  int          mismatched = 0;
  int          tp = 0;
  int          vs_rises = 0;
  int          vs_rise_tp = 0;
  int          vs_prev_rise_tp = 0;
  int          href_in_frame = 0;
  int          last_frame_hrefs = 0;
  int          href_rise_tp = 0;
  int          fs_cnt = 0;
  logic        vs_prev = 1'b0;
  logic        href_prev = 1'b0;
  logic        byte_phase = 1'b0;
  logic [7:0]  hi_byte = 8'h00;
  logic [15:0] exp_q [$];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Queue the pixels a whole frame of the given pattern should carry.
  task automatic push_frame(input bit counting);
    for (int r = 0; r < V_ACTIVE; r++)
      for (int c = 0; c < H_ACTIVE; c++)
        if (counting) exp_q.push_back(16'((r * H_ACTIVE + c) % 65536));
        else          exp_q.push_back(BAR_TAB[c / (H_ACTIVE / 8)]);
  endtask

  // Advance to the next sample point, half a clk after a pclk rise, and track edges.
  task automatic step_tp();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (cam.frameStart === 1'b1) begin
        fs_cnt++;
        check_output("frame_start_vsync", cam.vsync, 1);
      end
    end while (cam.pclk !== 1'b1 && guard < 4);
    if (cam.pclk !== 1'b1) check_output("pclk_running", cam.pclk, 1);
    tp++;
    if (cam.vsync && !vs_prev) begin
      vs_rises++;
      vs_prev_rise_tp  = vs_rise_tp;
      vs_rise_tp       = tp;
      last_frame_hrefs = href_in_frame;
      href_in_frame    = 0;
    end
    if (!cam.vsync && vs_prev) check_output("vsync_len", tp - vs_rise_tp, V_SYNC * LINE);
    if (cam.href && !href_prev) begin
      href_in_frame++;
      href_rise_tp = tp;
      if (href_in_frame == 1)
        check_output("first_href", tp - vs_rise_tp, (V_SYNC + V_BACK) * LINE);
    end
    if (!cam.href && href_prev) check_output("href_len", tp - href_rise_tp, 2 * H_ACTIVE);
    if (cam.href) begin
      if (!byte_phase) begin
        hi_byte    = cam.data;
        byte_phase = 1'b1;
      end else begin
        byte_phase = 1'b0;
        compared++;
        assert (exp_q.size() != 0) else begin
          mismatched++;
          $error("[TB] FAIL pixel_extra: observed %02h%02h required none", hi_byte, cam.data);
        end
        if (exp_q.size() != 0) check_output("pixel", {hi_byte, cam.data}, exp_q.pop_front());
      end
    end else begin
      byte_phase = 1'b0;
      check_output("data_idle", cam.data, 0);
    end
    vs_prev   = cam.vsync;
    href_prev = cam.href;
  endtask

  task automatic wait_vsync(input string tag, input int budget);
    int n0;
    n0 = vs_rises;
    for (int i = 0; i < budget && vs_rises == n0; i++) step_tp();
    check_output(tag, vs_rises, n0 + 1);
  endtask

  task automatic apply_stimulus_enable(input logic pat);
    int n0, f0;
    step_tp();
    cam.patternSel = pat;
    cam.enable     = 1'b1;
    n0 = vs_rises;
    f0 = fs_cnt;
    step_tp();
    check_output("start_latency", vs_rises, n0 + 1);
    check_output("start_pulse", fs_cnt, f0 + 1);
  endtask

  initial begin
    logic prev;
    int   n0;
    reset          = 1'b1;
    cam.enable     = 1'b0;
    cam.patternSel = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_pclk", cam.pclk, 0);
    check_output("rst_vsync", cam.vsync, 0);
    check_output("rst_href", cam.href, 0);
    check_output("rst_data", cam.data, 0);
    check_output("rst_fs", cam.frameStart, 0);
    reset = 1'b0;

    $display("[TB] idle with enable low");
    prev = cam.pclk;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check_output("idle_pclk", cam.pclk, !prev);
      check_output("idle_vsync", cam.vsync, 0);
      check_output("idle_href", cam.href, 0);
      check_output("idle_data", cam.data, 0);
      prev = cam.pclk;
    end

    $display("[TB] frame A colour bars, then two counting frames");
    push_frame(1'b0);
    apply_stimulus_enable(1'b0);
    cam.patternSel = 1'b1;
    push_frame(1'b1);
    wait_vsync("vsync_B", FRAME_TP + 20);
    check_output("period_AB", vs_rise_tp - vs_prev_rise_tp, FRAME_TP);
    check_output("hrefs_A", last_frame_hrefs, V_ACTIVE);
    check_output("fs_count_B", fs_cnt, 2);
    push_frame(1'b1);
    wait_vsync("vsync_C", FRAME_TP + 20);
    check_output("period_BC", vs_rise_tp - vs_prev_rise_tp, FRAME_TP);
    check_output("hrefs_B", last_frame_hrefs, V_ACTIVE);

    $display("[TB] change pattern and drop enable inside ACTIVE");
    for (int i = 0; i < 200 && href_in_frame < 1; i++) step_tp();
    repeat (10) step_tp();
    cam.patternSel = 1'b0;
    cam.enable     = 1'b0;
    n0 = vs_rises;
    repeat (300) step_tp();
    check_output("no_vsync_after_drop", vs_rises, n0);
    check_output("hrefs_C", href_in_frame, V_ACTIVE);
    check_output("queue_drained_C", exp_q.size(), 0);

    $display("[TB] re-enable with bars, reset during second href");
    push_frame(1'b0);
    apply_stimulus_enable(1'b0);
    for (int i = 0; i < 200 && href_in_frame < 2; i++) step_tp();
    check_output("second_href_reached", href_in_frame, 2);
    repeat (6) step_tp();
    #2;
    reset      = 1'b1;
    cam.enable = 1'b0;
    #1;
    check_output("async_pclk", cam.pclk, 0);
    check_output("async_vsync", cam.vsync, 0);
    check_output("async_href", cam.href, 0);
    check_output("async_data", cam.data, 0);
    check_output("async_fs", cam.frameStart, 0);
    exp_q.delete();
    byte_phase = 1'b0;
    href_prev  = 1'b0;
    vs_prev    = 1'b0;
    repeat (3) @(negedge clk);
    check_output("held_pclk", cam.pclk, 0);
    reset = 1'b0;
    n0 = vs_rises;
    repeat (40) step_tp();
    check_output("no_vsync_after_reset", vs_rises, n0);

    $display("[TB] restart with counting pattern, enable dropped right after start");
    cam.patternSel = 1'b1;
    push_frame(1'b1);
    apply_stimulus_enable(1'b1);
    cam.enable = 1'b0;
    n0 = vs_rises;
    repeat (FRAME_TP + 20) step_tp();
    check_output("no_vsync_final", vs_rises, n0);
    check_output("hrefs_final", href_in_frame, V_ACTIVE);
    check_output("queue_drained_final", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
